// File: rtl/riscv_pkg.sv
// ============================================================================
// Module : riscv_pkg
// Brief  : Shared MMIO register map, STATUS bit indices and helper functions.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package riscv_pkg;

    typedef enum logic [3:0] {
        MMIO_UART_TX     = 4'd0,
        MMIO_STATUS      = 4'd1,
        MMIO_MTIME_LO    = 4'd2,
        MMIO_MTIME_HI    = 4'd3,
        MMIO_MTIMECMP_LO = 4'd4,
        MMIO_MTIMECMP_HI = 4'd5,
        MMIO_MSIP        = 4'd6,
        MMIO_TX_LEVEL    = 4'd7,
        MMIO_SCRATCH0    = 4'd8,
        MMIO_SCRATCH1    = 4'd9
    } mmio_reg_e;

    localparam int STATUS_HALF_BIT  = 1;
    localparam int STATUS_OVF_BIT   = 2;
    localparam int STATUS_EMPTY_BIT = 3;
    localparam int STATUS_FULL_BIT  = 4;

    localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

    function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
        logic [31:0] merged;
        for (int b = 0; b < 4; b++) begin
            merged[b*8 +: 8] = be[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
        end
        return merged;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mmio_tx_fifo.sv
// ============================================================================
// Module : mmio_tx_fifo
// Brief  : Synchronous FIFO; a pop frees a slot for a same-cycle push when full.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mmio_tx_fifo #(
    parameter  int DEPTH = 8,
    parameter  int WIDTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [CW-1:0]    o_count,
    output logic             o_drop
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign o_full  = (count_q == CW'(DEPTH));
    assign o_empty = (count_q == '0);
    assign o_count = count_q;
    assign o_data  = mem_q[rd_ptr_q];

    assign pop_ok  = i_pop & ~o_empty;
    assign push_ok = i_push & (~o_full | pop_ok);
    assign o_drop  = i_push & ~push_ok;

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= i_data;
    end

endmodule

`default_nettype wire

// File: rtl/mmio_responder.sv
// ============================================================================
// Module : mmio_responder
// Brief  : MMIO window responder: UART TX FIFO, machine timer, scratch regs.
//          Define MMIO_TIMER_EN to build the mtime/mtimecmp timer and IRQ.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mmio_responder
    import riscv_pkg::*;
#(
    parameter int          XLEN            = 32,
    parameter logic [31:0] MMIO_ADDR       = 32'h4000_0000,
    parameter logic [31:0] MMIO_SIZE_BYTES = 32'h28,
    parameter int          TX_FIFO_DEPTH   = 8
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [XLEN-1:0] i_addr,
    input  logic            i_rd_en,
    input  logic            i_wr_en,
    input  logic [3:0]      i_byte_en,
    input  logic [XLEN-1:0] i_wr_data,
    output logic [XLEN-1:0] o_rd_data,
    output logic [7:0]      o_uart_tx_data,
    output logic            o_uart_tx_valid,
    input  logic            i_uart_tx_ready,
    output logic            o_timer_irq
);

    localparam int CW = $clog2(TX_FIFO_DEPTH) + 1;

    logic [XLEN-1:0] addr_off;
    logic            hit;
    logic            wr_hit;
    mmio_reg_e       reg_sel;

    logic            fifo_push, fifo_full, fifo_empty, fifo_drop;
    logic [CW-1:0]   fifo_count;

    logic [XLEN-1:0] rd_mux;
    logic [XLEN-1:0] status_word;
    logic [63:0]     mtime_rd, mtimecmp_rd;

    logic [XLEN-1:0] rd_data_q, rd_data_d;
    logic            ovf_q, ovf_d;
    logic            msip_q, msip_d;
    logic [XLEN-1:0] scratch0_q, scratch0_d;
    logic [XLEN-1:0] scratch1_q, scratch1_d;

    // Unsigned offset compare covers both window bounds in one test.
    assign addr_off = i_addr - MMIO_ADDR;
    assign hit      = (addr_off < MMIO_SIZE_BYTES);
    assign reg_sel  = mmio_reg_e'(addr_off[5:2]);
    assign wr_hit   = i_wr_en & hit;

    assign fifo_push = wr_hit & (reg_sel == MMIO_UART_TX) & i_byte_en[0];

    mmio_tx_fifo #(
        .DEPTH (TX_FIFO_DEPTH),
        .WIDTH (8)
    ) u_tx_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (fifo_push),
        .i_data  (i_wr_data[7:0]),
        .i_pop   (i_uart_tx_ready),
        .o_data  (o_uart_tx_data),
        .o_full  (fifo_full),
        .o_empty (fifo_empty),
        .o_count (fifo_count),
        .o_drop  (fifo_drop)
    );

    assign o_uart_tx_valid = ~fifo_empty;

`ifdef MMIO_TIMER_EN
    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic        irq_q;

    // Writing either half freezes the whole counter for that cycle.
    always_comb begin
        mtime_d    = mtime_q + 64'd1;
        mtimecmp_d = mtimecmp_q;
        if (wr_hit) begin
            case (reg_sel)
                MMIO_MTIME_LO:    mtime_d = {mtime_q[63:32],
                                             be_merge(mtime_q[31:0], i_wr_data, i_byte_en)};
                MMIO_MTIME_HI:    mtime_d = {be_merge(mtime_q[63:32], i_wr_data, i_byte_en),
                                             mtime_q[31:0]};
                MMIO_MTIMECMP_LO: mtimecmp_d = {mtimecmp_q[63:32],
                                                be_merge(mtimecmp_q[31:0], i_wr_data, i_byte_en)};
                MMIO_MTIMECMP_HI: mtimecmp_d = {be_merge(mtimecmp_q[63:32], i_wr_data, i_byte_en),
                                                mtimecmp_q[31:0]};
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mtime_q    <= '0;
            mtimecmp_q <= MTIMECMP_RST;
            irq_q      <= 1'b0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            irq_q      <= (mtime_q >= mtimecmp_q);
        end
    end

    assign mtime_rd    = mtime_q;
    assign mtimecmp_rd = mtimecmp_q;
    assign o_timer_irq = irq_q;
`else
    assign mtime_rd    = '0;
    assign mtimecmp_rd = '0;
    assign o_timer_irq = 1'b0;
`endif

    always_comb begin
        status_word                   = '0;
        status_word[STATUS_FULL_BIT]  = fifo_full;
        status_word[STATUS_EMPTY_BIT] = fifo_empty;
        status_word[STATUS_OVF_BIT]   = ovf_q;
        status_word[STATUS_HALF_BIT]  = (fifo_count >= CW'(TX_FIFO_DEPTH / 2));
    end

    always_comb begin
        rd_mux = '0;
        case (reg_sel)
            MMIO_STATUS:      rd_mux = status_word;
            MMIO_MTIME_LO:    rd_mux = mtime_rd[31:0];
            MMIO_MTIME_HI:    rd_mux = mtime_rd[63:32];
            MMIO_MTIMECMP_LO: rd_mux = mtimecmp_rd[31:0];
            MMIO_MTIMECMP_HI: rd_mux = mtimecmp_rd[63:32];
            MMIO_MSIP:        rd_mux = {{(XLEN-1){1'b0}}, msip_q};
            MMIO_TX_LEVEL:    rd_mux = {{(XLEN-CW){1'b0}}, fifo_count};
            MMIO_SCRATCH0:    rd_mux = scratch0_q;
            MMIO_SCRATCH1:    rd_mux = scratch1_q;
            default:          rd_mux = '0;
        endcase
    end

    // Read data samples current state, so a same-cycle write is not visible.
    always_comb begin
        rd_data_d  = rd_data_q;
        ovf_d      = ovf_q;
        msip_d     = msip_q;
        scratch0_d = scratch0_q;
        scratch1_d = scratch1_q;

        if (i_rd_en) rd_data_d = hit ? rd_mux : '0;

        if (wr_hit) begin
            case (reg_sel)
                MMIO_STATUS:   if (i_byte_en[0] && i_wr_data[STATUS_OVF_BIT]) ovf_d = 1'b0;
                MMIO_MSIP:     if (i_byte_en[0]) msip_d = i_wr_data[0];
                MMIO_SCRATCH0: scratch0_d = be_merge(scratch0_q, i_wr_data, i_byte_en);
                MMIO_SCRATCH1: scratch1_d = be_merge(scratch1_q, i_wr_data, i_byte_en);
                default: ;
            endcase
        end

        if (fifo_drop) ovf_d = 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_data_q  <= '0;
            ovf_q      <= 1'b0;
            msip_q     <= 1'b0;
            scratch0_q <= '0;
            scratch1_q <= '0;
        end else begin
            rd_data_q  <= rd_data_d;
            ovf_q      <= ovf_d;
            msip_q     <= msip_d;
            scratch0_q <= scratch0_d;
            scratch1_q <= scratch1_d;
        end
    end

    assign o_rd_data = rd_data_q;

endmodule

`default_nettype wire
